adder_nbit_acc_pipe: RTL and testbench

//  Parametrised, registered two-operand adder with per-beat signed/unsigned mode
//  and an accumulate mode. Used as the reusable arithmetic datapath element

---
 rtl/adder_nbit_acc_pipe_if.sv | 32 +++
 rtl/adder_nbit_acc_pipe.sv | 87 ++++++++
 tb/tb_adder_nbit_acc_pipe.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/adder_nbit_acc_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_nbit_acc_pipe_if : valid/ready beat and result bus of the adder    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface adder_nbit_acc_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             is_signed;
   logic             acc_mode;
   logic             clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   z;
   logic             ovf;
   logic             ovf_sticky;

   modport master (
      output in_valid, x, y, is_signed, acc_mode, clr, out_ready,
      input  in_ready, out_valid, z, ovf, ovf_sticky
   );

   modport slave (
      input  in_valid, x, y, is_signed, acc_mode, clr, out_ready,
      output in_ready, out_valid, z, ovf, ovf_sticky
   );
endinterface
`default_nettype wire

// File: rtl/adder_nbit_acc_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_nbit_acc_pipe : registered WIDTH+1 adder/accumulator, valid/ready. |
// | Optional clamp on accumulate overflow: define ADDER_SATURATE_EN. Rev 1.0 |
// +--------------------------------------------------------------------------+
module adder_nbit_acc_pipe #(
   parameter int WIDTH = 8
) (
   input  wire logic             clk,
   input  wire logic             rstn,
   adder_nbit_acc_pipe_if.slave  bus
);
   localparam int c_ZW = WIDTH + 1;

   logic [c_ZW-1:0] r_acc;
   logic [c_ZW-1:0] r_z;
   logic            r_valid;
   logic            r_ovf;
   logic            r_sticky;

   logic            w_accept;
   logic [c_ZW-1:0] w_ext_x;
   logic [c_ZW-1:0] w_ext_y;
   logic [c_ZW-1:0] w_direct;
   logic [c_ZW-1:0] w_base;
   logic [c_ZW:0]   w_sum;
   logic            w_ovf;
   logic [c_ZW-1:0] w_acc_next;

   assign bus.in_ready = !r_valid || bus.out_ready;
   assign w_accept     = bus.in_valid && bus.in_ready;

   assign w_ext_x  = bus.is_signed ? {bus.x[WIDTH-1], bus.x} : {1'b0, bus.x};
   assign w_ext_y  = bus.is_signed ? {bus.y[WIDTH-1], bus.y} : {1'b0, bus.y};
   assign w_direct = w_ext_x + w_ext_y;

   // The stored sum is reinterpreted under this beat's signedness, not converted.
   assign w_base = bus.clr ? '0 : r_acc;
   assign w_sum  = {bus.is_signed & w_base[WIDTH], w_base}
                 + {bus.is_signed & w_ext_x[WIDTH], w_ext_x};
   assign w_ovf  = bus.is_signed ? (w_sum[c_ZW] ^ w_sum[WIDTH]) : w_sum[c_ZW];

`ifdef ADDER_SATURATE_EN
   always_comb begin
      w_acc_next = w_sum[WIDTH:0];
      if (w_ovf) begin
         if (!bus.is_signed)
            w_acc_next = '1;
         else if (w_sum[c_ZW])
            w_acc_next = {1'b1, {WIDTH{1'b0}}};
         else
            w_acc_next = {1'b0, {WIDTH{1'b1}}};
      end
   end
`else
   assign w_acc_next = w_sum[WIDTH:0];
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_valid  <= 1'b0;
         r_z      <= '0;
         r_ovf    <= 1'b0;
         r_sticky <= 1'b0;
         r_acc    <= '0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         if (bus.acc_mode) begin
            r_acc    <= w_acc_next;
            r_z      <= w_acc_next;
            r_ovf    <= w_ovf;
            r_sticky <= bus.clr ? w_ovf : (r_sticky | w_ovf);
         end else begin
            r_z   <= w_direct;
            r_ovf <= 1'b0;
         end
      end else if (bus.out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign bus.out_valid  = r_valid;
   assign bus.z          = r_z;
   assign bus.ovf        = r_ovf;
   assign bus.ovf_sticky = r_sticky;
endmodule
`default_nettype wire

// File: tb/tb_adder_nbit_acc_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_adder_nbit_acc_pipe : directed vectors for the WIDTH=4 adder. Rev 1.0 |
// +--------------------------------------------------------------------------+
module tb_adder_nbit_acc_pipe;
   localparam int c_W = 4;

   logic clk;
   logic rstn;
   int   chk_cnt;
   int   err_cnt;

   adder_nbit_acc_pipe_if #(.WIDTH(c_W)) bus ();

   adder_nbit_acc_pipe #(.WIDTH(c_W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One beat presented for a single edge; outputs are sampled 1 time unit later.
   task automatic beat(input logic [3:0] xv, input logic [3:0] yv,
                       input logic s, input logic a, input logic c);
      bus.in_valid  = 1'b1;
      bus.x         = xv;
      bus.y         = yv;
      bus.is_signed = s;
      bus.acc_mode  = a;
      bus.clr       = c;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      chk_cnt       = 0;
      err_cnt       = 0;
      rstn          = 1'b0;
      bus.in_valid  = 1'b0;
      bus.x         = '0;
      bus.y         = '0;
      bus.is_signed = 1'b0;
      bus.acc_mode  = 1'b0;
      bus.clr       = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid",  bus.out_valid,  0);
      check("rst_z",      bus.z,          0);
      check("rst_ovf",    bus.ovf,        0);
      check("rst_sticky", bus.ovf_sticky, 0);
      check("rst_ready",  bus.in_ready,   1);
      rstn = 1'b1;

      // Direct adds
      beat(4'hF, 4'h1, 0, 0, 0);
      check("dir_u_z", bus.z, 5'h10);
      check("dir_u_ovf", bus.ovf, 0);
      check("dir_u_valid", bus.out_valid, 1);
      beat(4'hF, 4'h1, 1, 0, 0);
      check("dir_s_z", bus.z, 5'h00);
      beat(4'h8, 4'h8, 1, 0, 0);
      check("dir_s_neg_z", bus.z, 5'h10);

      // Unsigned accumulate
      beat(4'hF, 4'h0, 0, 1, 1);
      check("uacc1_z", bus.z, 5'h0F);
      check("uacc1_ovf", bus.ovf, 0);
      beat(4'hF, 4'h0, 0, 1, 0);
      check("uacc2_z", bus.z, 5'h1E);
      beat(4'hF, 4'h0, 0, 1, 0);
`ifdef ADDER_SATURATE_EN
      check("uacc3_z", bus.z, 5'h1F);
`else
      check("uacc3_z", bus.z, 5'h0D);
`endif
      check("uacc3_ovf", bus.ovf, 1);
      check("uacc3_sticky", bus.ovf_sticky, 1);
      beat(4'h0, 4'h0, 0, 1, 0);
      check("uacc4_ovf", bus.ovf, 0);
      check("uacc4_sticky", bus.ovf_sticky, 1);

      // Signed accumulate
      beat(4'h7, 4'h0, 1, 1, 1);
      check("sacc1_z", bus.z, 5'h07);
      check("sacc1_sticky", bus.ovf_sticky, 0);
      beat(4'h7, 4'h0, 1, 1, 0);
      check("sacc2_z", bus.z, 5'h0E);
      beat(4'h7, 4'h0, 1, 1, 0);
`ifdef ADDER_SATURATE_EN
      check("sacc3_z", bus.z, 5'h0F);
`else
      check("sacc3_z", bus.z, 5'h15);
`endif
      check("sacc3_ovf", bus.ovf, 1);
      check("sacc3_sticky", bus.ovf_sticky, 1);
      beat(4'h8, 4'h0, 1, 1, 1);
      check("sacc4_z", bus.z, 5'h18);
      check("sacc4_ovf", bus.ovf, 0);
      check("sacc4_sticky", bus.ovf_sticky, 0);

      // A direct add between accumulate beats leaves the sum alone
      beat(4'h5, 4'h0, 0, 1, 1);
      check("mix1_z", bus.z, 5'h05);
      beat(4'hF, 4'hF, 0, 0, 0);
      check("mix2_z", bus.z, 5'h1E);
      beat(4'h1, 4'h0, 0, 1, 0);
      check("mix3_z", bus.z, 5'h06);

      // Backpressure: output stalls three cycles with a beat waiting
      beat(4'h3, 4'h0, 0, 1, 1);
      check("bp0_z", bus.z, 5'h03);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.x         = 4'h2;
      bus.is_signed = 1'b0;
      bus.acc_mode  = 1'b1;
      bus.clr       = 1'b0;
      #1;
      check("bp_ready0", bus.in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("bp_ready", bus.in_ready, 0);
         check("bp_hold_z", bus.z, 5'h03);
         check("bp_hold_valid", bus.out_valid, 1);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("bp_next_z", bus.z, 5'h05);
      check("bp_next_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
      check("drain_valid", bus.out_valid, 0);

      // Build acc=0x0E, reinterpreting an unsigned 15 as signed, then reset
      beat(4'hF, 4'h0, 0, 1, 1);
      check("pre1_z", bus.z, 5'h0F);
      beat(4'hF, 4'h0, 1, 1, 0);
      check("pre2_z", bus.z, 5'h0E);
      check("pre2_ovf", bus.ovf, 0);
      bus.out_ready = 1'b0;
      rstn          = 1'b0;
      @(posedge clk);
      #1;
      check("mrst_valid", bus.out_valid, 0);
      check("mrst_z", bus.z, 0);
      check("mrst_sticky", bus.ovf_sticky, 0);
      rstn          = 1'b1;
      bus.out_ready = 1'b1;
      beat(4'h3, 4'h0, 0, 1, 0);
      check("post_rst_z", bus.z, 5'h03);

      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end
endmodule
`default_nettype wire
